sram_ctrl: RTL and testbench

Sequencer and arbiter for one asynchronous 32-bit SRAM chip (active-low CE/OE/WE, word-addressed, bidirectional data bus). Shares the chip between an instruction-fetch port (read-only) and a data port (read/write), with round-robin on contention. Generates glitch-free strobe sequences: OE and WE are never low together, and data is held stable across the WE rising edge. Sits between the CPU memory stage/fetch unit and the board SRAM pins.

---
 rtl/sram_ctrl_pkg.sv | 17 +
 rtl/sram_rr_arbiter.sv | 35 +++
 rtl/sram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM sequencer/arbiter.
// Port IDs double as bit positions in the arbiter's eligible vector.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int   DATA_W = 32;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin arbiter. On a tie the port not granted last wins;
// the history bit only moves when the sequencer actually takes the grant.
module sram_rr_arbiter
  import sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_eligible,
  input  logic       i_update,
  output logic       o_valid,
  output logic       o_grant
);

  logic r_last;

  always_comb begin
    o_valid = |i_eligible;
    if (&i_eligible) begin
      o_grant = ~r_last;
    end else if (i_eligible[PORT_D]) begin
      o_grant = PORT_D;
    end else begin
      o_grant = PORT_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= PORT_I;
    end else if (i_update && o_valid) begin
      r_last <= o_grant;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Sequencer for one asynchronous 32-bit SRAM shared by a fetch port and a
// data port. All strobes and the bus drive-enable are registered (glitch-free).
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int READ_WAIT  = 1,
  parameter int WE_PULSE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_W-1:0]     ram_data,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n
);

  localparam int CNT_MAX = (READ_WAIT > WE_PULSE) ? READ_WAIT : WE_PULSE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [DATA_W-1:0]     r_wdata, w_wdata_next;
  logic [DATA_W-1:0]     r_rdata, w_rdata_next;
  logic                  r_port, w_port_next;
  logic                  r_ce_n, w_ce_n_next;
  logic                  r_oe_n, w_oe_n_next;
  logic                  r_we_n, w_we_n_next;
  logic                  r_drive, w_drive_next;
  logic                  r_i_ack, w_i_ack_next;
  logic                  r_d_ack, w_d_ack_next;

  logic [1:0] w_eligible;
  logic       w_valid;
  logic       w_grant;
  logic       w_update;

  // A port is not eligible in its own ack cycle, so its held request is not re-served.
  assign w_eligible = {d_req & ~r_d_ack, i_req & ~r_i_ack};

  sram_rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_eligible (w_eligible),
    .i_update   (w_update),
    .o_valid    (w_valid),
    .o_grant    (w_grant)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    w_rdata_next = r_rdata;
    w_port_next  = r_port;
    w_ce_n_next  = r_ce_n;
    w_oe_n_next  = r_oe_n;
    w_we_n_next  = r_we_n;
    w_drive_next = r_drive;
    w_i_ack_next = 1'b0;
    w_d_ack_next = 1'b0;
    w_update     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_update    = 1'b1;
          w_port_next = w_grant;
          w_ce_n_next = 1'b0;
          if (w_grant == PORT_D) begin
            w_addr_next  = d_addr;
            w_wdata_next = d_wdata;
          end else begin
            w_addr_next = i_addr;
          end
          if (w_grant == PORT_D && d_we) begin
            w_drive_next = 1'b1;
            w_state_next = ST_WR_SETUP;
          end else begin
            w_oe_n_next  = 1'b0;
            w_cnt_next   = CNT_W'(READ_WAIT);
            w_state_next = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_rdata_next = ram_data;
          w_ce_n_next  = 1'b1;
          w_oe_n_next  = 1'b1;
          w_i_ack_next = (r_port == PORT_I);
          w_d_ack_next = (r_port == PORT_D);
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        w_we_n_next  = 1'b0;
        w_cnt_next   = CNT_W'(WE_PULSE);
        w_state_next = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (r_cnt == CNT_W'(1)) begin
          w_we_n_next  = 1'b1;
          w_state_next = ST_WR_HOLD;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
        w_drive_next = 1'b0;
        w_ce_n_next  = 1'b1;
        w_d_ack_next = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_port  <= PORT_I;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_drive <= 1'b0;
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
      r_rdata <= w_rdata_next;
      r_port  <= w_port_next;
      r_ce_n  <= w_ce_n_next;
      r_oe_n  <= w_oe_n_next;
      r_we_n  <= w_we_n_next;
      r_drive <= w_drive_next;
      r_i_ack <= w_i_ack_next;
      r_d_ack <= w_d_ack_next;
    end
  end

  assign ram_data = r_drive ? r_wdata : 'z;
  assign ram_addr = r_addr;
  assign ram_ce_n = r_ce_n;
  assign ram_oe_n = r_oe_n;
  assign ram_we_n = r_we_n;
  assign rdata    = r_rdata;
  assign i_ack    = r_i_ack;
  assign d_ack    = r_d_ack;

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl: an SRAM chip model on the bus, a reference
// memory image, a strobe-protocol monitor, and a second instance with longer timing.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [19:0] i_addr, d_addr;
  logic [31:0] d_wdata;
  logic        i_ack, d_ack;
  logic [31:0] rdata;
  logic [19:0] ram_addr;
  wire  [31:0] ram_data;
  logic        ram_ce_n, ram_oe_n, ram_we_n;

  logic        i_req2, d_req2, d_we2;
  logic [19:0] i_addr2, d_addr2;
  logic [31:0] d_wdata2;
  logic        i_ack2, d_ack2;
  logic [31:0] rdata2;
  logic [19:0] ram_addr2;
  wire  [31:0] ram_data2;
  logic        ram_ce_n2, ram_oe_n2, ram_we_n2;

  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [31:0] chip    [0:255];
  logic [31:0] exp_mem [0:255];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [19:0] a);
    return 32'h13579BDF ^ (32'(a) * 32'h9E3779B1);
  endfunction

  sram_ctrl u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  sram_ctrl #(.ADDR_WIDTH(20), .READ_WAIT(3), .WE_PULSE(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .i_req(i_req2), .i_addr(i_addr2), .i_ack(i_ack2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2), .d_ack(d_ack2),
    .rdata(rdata2), .ram_addr(ram_addr2), .ram_data(ram_data2),
    .ram_ce_n(ram_ce_n2), .ram_oe_n(ram_oe_n2), .ram_we_n(ram_we_n2)
  );

  // Chip models: drive the bus only while selected for read.
  assign ram_data  = (!ram_ce_n && !ram_oe_n && ram_we_n) ? chip[ram_addr[7:0]] : 'z;
  assign ram_data2 = (!ram_ce_n2 && !ram_oe_n2 && ram_we_n2) ? img(ram_addr2) : 'z;

  // Protocol monitor and chip write capture on the WE rising edge.
  logic        prev_ce_n = 1'b1, prev_oe_n = 1'b1, prev_we_n = 1'b1;
  logic [31:0] setup_d = '0, fall_d = '0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      n_vec++;
      if ((!ram_oe_n && !ram_we_n) || (!ram_oe_n2 && !ram_we_n2)) begin
        n_err++;
        $display("FAIL strobe_overlap: oe_n=%b we_n=%b oe_n2=%b we_n2=%b, required never both 0",
                 ram_oe_n, ram_we_n, ram_oe_n2, ram_we_n2);
      end
      if (!ram_ce_n && !ram_oe_n) begin
        n_vec++;
        if (ram_data !== chip[ram_addr[7:0]] || ram_addr[19:8] != 12'h0) begin
          n_err++;
          $display("FAIL read_bus: addr=%h bus=%h, required chip word %h with bus undriven by controller",
                   ram_addr, ram_data, chip[ram_addr[7:0]]);
        end
      end
      if (!ram_ce_n && prev_ce_n && ram_oe_n) setup_d = ram_data;
      if (!ram_we_n && prev_we_n) begin
        n_vec++;
        if (prev_oe_n !== 1'b1 || ram_data !== setup_d) begin
          n_err++;
          $display("FAIL we_fall: prev_oe_n=%b bus=%h, required oe_n high before and data %h set up",
                   prev_oe_n, ram_data, setup_d);
        end
        fall_d = ram_data;
      end
      if (ram_we_n && !prev_we_n && !ram_ce_n) begin
        n_vec++;
        if (ram_data !== fall_d) begin
          n_err++;
          $display("FAIL we_hold: bus=%h after WE rise, required %h", ram_data, fall_d);
        end
        chip[ram_addr[7:0]] = ram_data;
      end
    end
    prev_ce_n = ram_ce_n;
    prev_oe_n = ram_oe_n;
    prev_we_n = ram_we_n;
  end

  // Runs one access from IDLE; lat is cycles from grant edge to ack edge (-1 on timeout).
  task automatic access(input bit pd, input bit we, input logic [19:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output int other,
                        output logic ack_after);
    lat = -1; rd = '0; other = 0;
    if (pd) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (pd ? i_ack : d_ack) other++;
      if (pd ? d_ack : i_ack) begin
        lat = c - 1;
        rd  = rdata;
        break;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    ack_after = pd ? d_ack : i_ack;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, i_ack, d_ack} !== 5'b11100 || rdata !== 32'h0 || ram_addr !== 20'h0) begin
      n_err++;
      $display("FAIL reset_state: strobes/acks=%b rdata=%h addr=%h, required 11100 0 0",
               {ram_ce_n, ram_oe_n, ram_we_n, i_ack, d_ack}, rdata, ram_addr);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat, oth; logic [31:0] rd; logic aa;
    access(1'b1, 1'b1, 20'h00010, 32'hDEADBEEF, lat, rd, oth, aa);
    exp_mem[8'h10] = 32'hDEADBEEF;
    n_vec++;
    if (lat != 3 || aa !== 1'b0 || oth != 0) begin
      n_err++;
      $display("FAIL write_latency: lat=%0d ack_after=%b other_acks=%0d, required 3 0 0", lat, aa, oth);
    end
    access(1'b1, 1'b0, 20'h00010, 32'h0, lat, rd, oth, aa);
    exp_rdata = exp_mem[8'h10];
    n_vec++;
    if (lat != 1 || rd !== exp_rdata || aa !== 1'b0) begin
      n_err++;
      $display("FAIL read_back: lat=%0d rdata=%h ack_after=%b, required 1 %h 0", lat, rd, aa, exp_rdata);
    end
  endtask

  task automatic test_fetch();
    int lat, oth; logic [31:0] rd; logic aa;
    access(1'b0, 1'b0, 20'h00000, 32'h0, lat, rd, oth, aa);
    exp_rdata = exp_mem[0];
    n_vec++;
    if (lat != 1 || rd !== exp_rdata || oth != 0 || aa !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_read: lat=%0d rdata=%h d_acks=%0d ack_after=%b, required 1 %h 0 0",
               lat, rd, oth, aa, exp_rdata);
    end
  endtask

  task automatic test_contention();
    logic [19:0] ia, da;
    bit last_d, got_d, pi, pd;
    int n;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ia = 20'($urandom_range(64, 255));
    da = 20'($urandom_range(64, 255));
    i_addr = ia; d_addr = da; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    last_d = 1'b0; n = 0; pi = 1'b0; pd = 1'b0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(posedge clk); #1;
      if (i_ack || d_ack) begin
        got_d = d_ack;
        n_vec++;
        if ((i_ack && d_ack) || got_d != ~last_d || (i_ack && pi) || (d_ack && pd)) begin
          n_err++;
          $display("FAIL rr_order: grant #%0d i_ack=%b d_ack=%b, required only %s ack, one cycle wide",
                   n, i_ack, d_ack, last_d ? "fetch" : "data");
        end
        exp_rdata = exp_mem[got_d ? da[7:0] : ia[7:0]];
        n_vec++;
        if (rdata !== exp_rdata) begin
          n_err++;
          $display("FAIL rr_rdata: grant #%0d rdata=%h, required %h", n, rdata, exp_rdata);
        end
        last_d = got_d;
        n++;
        if (n == 4) begin
          i_req = 1'b0; d_req = 1'b0;
        end
      end
      pi = i_ack; pd = d_ack;
    end
    i_req = 1'b0; d_req = 1'b0;
    n_vec++;
    if (n != 4) begin
      n_err++;
      $display("FAIL rr_count: %0d grants completed, required 4", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    int lat, oth; logic [31:0] rd; logic aa;
    bit found = 1'b0;
    bit spurious = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 20'h00020; d_wdata = $urandom;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (d_ack) spurious = 1'b1;
      if (!ram_we_n) begin
        found = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (!found || {ram_ce_n, ram_oe_n, ram_we_n, i_ack, d_ack} !== 5'b11100 ||
        rdata !== 32'h0 || ram_addr !== 20'h0) begin
      n_err++;
      $display("FAIL reset_mid_write: reached_pulse=%b strobes/acks=%b rdata=%h addr=%h, required 1 11100 0 0",
               found, {ram_ce_n, ram_oe_n, ram_we_n, i_ack, d_ack}, rdata, ram_addr);
    end
    d_req = 1'b0;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (d_ack || i_ack) spurious = 1'b1;
    end
    n_vec++;
    if (spurious) begin
      n_err++;
      $display("FAIL abandoned_ack: ack seen for interrupted write, required none");
    end
    access(1'b1, 1'b0, 20'h00010, 32'h0, lat, rd, oth, aa);
    exp_rdata = exp_mem[8'h10];
    n_vec++;
    if (lat != 1 || rd !== exp_rdata) begin
      n_err++;
      $display("FAIL read_after_reset: lat=%0d rdata=%h, required 1 %h", lat, rd, exp_rdata);
    end
  endtask

  task automatic test_random();
    int lat, oth; logic [31:0] rd, wd; logic aa;
    bit pd, we;
    logic [19:0] a;
    for (int k = 0; k < 40; k++) begin
      pd = 1'($urandom_range(0, 1));
      we = pd ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = 20'($urandom_range(64, 255));
      wd = $urandom;
      access(pd, we, a, wd, lat, rd, oth, aa);
      if (we) begin
        exp_mem[a[7:0]] = wd;
      end else begin
        exp_rdata = exp_mem[a[7:0]];
      end
      n_vec++;
      if (lat != (we ? 3 : 1) || rd !== exp_rdata || oth != 0 || aa !== 1'b0) begin
        n_err++;
        $display("FAIL random[%0d]: %s %s addr=%h lat=%0d rdata=%h other=%0d ack_after=%b, required lat %0d rdata %h",
                 k, pd ? "D" : "I", we ? "WR" : "RD", a, lat, rd, oth, aa, we ? 3 : 1, exp_rdata);
      end
    end
  endtask

  task automatic test_params();
    logic [19:0] a;
    int lat, wel;
    for (int op = 0; op < 2; op++) begin
      a = 20'($urandom_range(0, 255));
      d_req2 = 1'b1; d_we2 = (op == 1); d_addr2 = a; d_wdata2 = $urandom;
      lat = -1; wel = 0;
      for (int c = 1; c <= 30; c++) begin
        @(posedge clk); #1;
        if (!ram_we_n2) wel++;
        if (d_ack2) begin
          lat = c - 1;
          break;
        end
      end
      n_vec++;
      if (op == 0 && (lat != 3 || rdata2 !== img(a) || wel != 0)) begin
        n_err++;
        $display("FAIL param_read: lat=%0d rdata=%h, required 3 %h", lat, rdata2, img(a));
      end
      if (op == 1 && (lat != 4 || wel != 2)) begin
        n_err++;
        $display("FAIL param_write: lat=%0d we_low_cycles=%0d, required 4 2", lat, wel);
      end
      d_req2 = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (d_ack2 !== 1'b0 || i_ack2 !== 1'b0) begin
        n_err++;
        $display("FAIL param_ack_width: d_ack=%b i_ack=%b, required 0 0", d_ack2, i_ack2);
      end
    end
  endtask

  initial begin
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    i_req2 = 1'b0; d_req2 = 1'b0; d_we2 = 1'b0;
    i_addr2 = '0; d_addr2 = '0; d_wdata2 = '0;
    exp_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      chip[i]    = img(20'(i));
      exp_mem[i] = img(20'(i));
    end
    test_reset();
    test_write_read();
    test_fetch();
    test_contention();
    test_reset_mid_write();
    test_random();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
